// File: rtl/alu_pkg.sv
// Shared types and constants for the receive front end of the ALU pipeline.
// No logic. Frame geometry and idle-timer width live here.
// No handshaking. Consumers import this package with alu_pkg::*.
package alu_pkg;

    localparam int FRAME_BYTES = 5;
    localparam int RX_TMO_W    = 16;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_COLLECT = 2'd1,
        RX_HOLD    = 2'd2
    } rx_state_t;

endpackage

// File: rtl/rx_idle_timer.sv
// Idle counter for partial frames. It is built only when RX_TIMEOUT_EN is defined.
// Latency: expired is combinational and is raised on the cycle whose edge would reach TIMEOUT_CYCLES.
// Backpressure: none. The counter counts while run is high, and clear takes precedence over run.
module rx_idle_timer
    import alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam logic [RX_TMO_W-1:0] LAST = RX_TMO_W'(TIMEOUT_CYCLES - 1);

    logic [RX_TMO_W-1:0] r_cnt;

    assign expired = run && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || expired) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= r_cnt + RX_TMO_W'(1);
        end
    end

endmodule

// File: rtl/rx_stage.sv
// Byte-serial receiver that assembles op/a1/a2/b1/b2 frames for decode_stage. The idle timeout is enabled by RX_TIMEOUT_EN.
// Latency: rx_valid_out rises on the edge that accepts the fifth byte. A frame needs at least 6 cycles.
// Backpressure: in_ready stays low in HOLD until dec_ready_in takes the frame. A host byte offered during HOLD waits.
module rx_stage
    import alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       dec_ready_in,
    output logic       rx_valid_out,
    output logic [7:0] op,
    output logic [7:0] a1,
    output logic [7:0] a2,
    output logic [7:0] b1,
    output logic [7:0] b2,
    output logic       frame_err
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

    rx_state_t  r_state;
    logic [2:0] r_cnt;
    logic [7:0] r_op, r_a1, r_a2, r_b1, r_b2;
    logic       w_accept;
    logic       w_tmo;

    assign in_ready     = (r_state != RX_HOLD);
    assign rx_valid_out = (r_state == RX_HOLD);
    assign w_accept     = in_valid && in_ready;

    assign op = r_op;
    assign a1 = r_a1;
    assign a2 = r_a2;
    assign b1 = r_b1;
    assign b2 = r_b2;

`ifdef RX_TIMEOUT_EN
    logic r_frame_err;

    // An accept on the expiring cycle suppresses run, so the byte wins over the timeout.
    rx_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    ((r_state == RX_COLLECT) && !w_accept),
        .clear  (w_accept || (r_state != RX_COLLECT)),
        .expired(w_tmo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_tmo;
        end
    end

    assign frame_err = r_frame_err;
`else
    assign w_tmo     = 1'b0;
    assign frame_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RX_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            case (r_state)
                RX_IDLE: begin
                    if (w_accept) begin
                        r_state <= RX_COLLECT;
                        r_cnt   <= 3'd1;
                    end
                end
                RX_COLLECT: begin
                    if (w_accept) begin
                        if (r_cnt == LAST_IDX) begin
                            r_state <= RX_HOLD;
                            r_cnt   <= 3'd0;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end else if (w_tmo) begin
                        r_state <= RX_IDLE;
                        r_cnt   <= 3'd0;
                    end
                end
                RX_HOLD: begin
                    if (dec_ready_in) begin
                        r_state <= RX_IDLE;
                    end
                end
                default: begin
                    r_state <= RX_IDLE;
                    r_cnt   <= 3'd0;
                end
            endcase
        end
    end

    // Fields change only on their own accept. They keep their values after a transfer or a timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op <= 8'h00;
            r_a1 <= 8'h00;
            r_a2 <= 8'h00;
            r_b1 <= 8'h00;
            r_b2 <= 8'h00;
        end else if (w_accept) begin
            case (r_cnt)
                3'd0:    r_op <= in_data;
                3'd1:    r_a1 <= in_data;
                3'd2:    r_a2 <= in_data;
                3'd3:    r_b1 <= in_data;
                3'd4:    r_b2 <= in_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_stage.sv
// Bench for rx_stage: table-driven frames plus hand sequences for reset, backpressure and idle timeout.
// A scoreboard queue holds expected frames and is checked whenever a frame transfers to decode.
module tb_rx_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       dec_ready_in;
    logic       rx_valid_out;
    logic [7:0] op, a1, a2, b1, b2;
    logic       frame_err;
    logic [39:0] w_fields;

    always #5 clk = ~clk;

    assign w_fields = {op, a1, a2, b1, b2};

    rx_stage #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .dec_ready_in(dec_ready_in),
        .rx_valid_out(rx_valid_out),
        .op          (op),
        .a1          (a1),
        .a2          (a2),
        .b1          (b1),
        .b2          (b2),
        .frame_err   (frame_err)
    );

    typedef struct {
        logic [39:0] frame;
        int          gap;
        int          rdy_dly;
        int          exp_hold;
    } vec_t;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [39:0] exp_q[$];
    vec_t        vt[4];

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50 && !in_ready; i++) tick();
        if (!in_ready) chk("in_ready_wait", {39'd0, in_ready}, 40'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [39:0] f, input int gap);
        exp_q.push_back(f);
        for (int k = 0; k < 5; k++) send_byte(f[39-8*k -: 8], gap);
    endtask

    task automatic run_vec(input vec_t v);
        int hold;
        dec_ready_in = (v.rdy_dly == 0);
        send_frame(v.frame, v.gap);
        chk("valid_after_5th", {39'd0, rx_valid_out}, 40'd1);
        chk("in_ready_in_hold", {39'd0, in_ready}, 40'd0);
        hold = 0;
        repeat (v.rdy_dly) begin
            hold++;
            tick();
        end
        dec_ready_in = 1'b1;
        while (rx_valid_out && hold < 100) begin
            hold++;
            tick();
        end
        chk("hold_cycles", 40'(hold), 40'(v.exp_hold));
        chk("valid_after_xfer", {39'd0, rx_valid_out}, 40'd0);
        chk("ready_after_xfer", {39'd0, in_ready}, 40'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic err_seen;
        vec_t v;

        vt[0] = '{frame: 40'h01_11_22_33_44, gap: 0, rdy_dly: 0, exp_hold: 1};
        vt[1] = '{frame: 40'h01_11_22_33_44, gap: 3, rdy_dly: 0, exp_hold: 1};
        vt[2] = '{frame: 40'hA5_5A_C3_3C_00, gap: 1, rdy_dly: 2, exp_hold: 3};
        vt[3] = '{frame: 40'hFF_FE_80_7F_01, gap: 0, rdy_dly: 5, exp_hold: 6};

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        dec_ready_in = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (rst_n && rx_valid_out && dec_ready_in) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL sb_unexpected: got %h expected no frame", w_fields);
                    end else begin
                        chk("sb_frame", w_fields, exp_q.pop_front());
                    end
                end
            end
        join_none

        #12;
        chk("rst_in_ready", {39'd0, in_ready}, 40'd1);
        chk("rst_valid", {39'd0, rx_valid_out}, 40'd0);
        chk("rst_fields", w_fields, 40'd0);
        chk("rst_frame_err", {39'd0, frame_err}, 40'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) run_vec(vt[i]);

        // Backpressure: the host offers FF throughout HOLD.
        dec_ready_in = 1'b0;
        send_frame(40'h5A_6B_7C_8D_9E, 0);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", {39'd0, rx_valid_out}, 40'd1);
            chk("bp_in_ready", {39'd0, in_ready}, 40'd0);
            chk("bp_fields", w_fields, 40'h5A_6B_7C_8D_9E);
        end
        dec_ready_in = 1'b1;
        exp_q.push_back(40'hFF_01_02_03_04);
        tick();
        chk("bp_xfer_valid", {39'd0, rx_valid_out}, 40'd0);
        chk("bp_xfer_ready", {39'd0, in_ready}, 40'd1);
        chk("bp_op_kept", {32'd0, op}, 40'h5A);
        tick();
        chk("bp_ff_captured", {32'd0, op}, 40'hFF);
        in_valid = 1'b0;
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        chk("bp_next_valid", {39'd0, rx_valid_out}, 40'd1);
        tick();

        // Reset in the middle of a frame.
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {39'd0, in_ready}, 40'd1);
        chk("mid_rst_valid", {39'd0, rx_valid_out}, 40'd0);
        chk("mid_rst_fields", w_fields, 40'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_vec(vt[0]);

        // Reset during HOLD. This frame never reaches decode.
        dec_ready_in = 1'b0;
        for (int k = 0; k < 5; k++) send_byte(8'h40 + 8'(k), 0);
        chk("hold_rst_pre_valid", {39'd0, rx_valid_out}, 40'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("hold_rst_valid", {39'd0, rx_valid_out}, 40'd0);
        chk("hold_rst_ready", {39'd0, in_ready}, 40'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

`ifdef RX_TIMEOUT_EN
        dec_ready_in = 1'b1;
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        err_seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            err_seen |= frame_err;
        end
        chk("tmo_early", {39'd0, err_seen}, 40'd0);
        tick();
        chk("tmo_pulse", {39'd0, frame_err}, 40'd1);
        chk("tmo_fields_kept", {32'd0, op}, 40'hAA);
        tick();
        chk("tmo_pulse_end", {39'd0, frame_err}, 40'd0);
        v = '{frame: 40'h02_05_06_07_08, gap: 0, rdy_dly: 0, exp_hold: 1};
        run_vec(v);
        chk("tmo_next_op", {32'd0, op}, 40'h02);

        // An accept on the expiring cycle must win over the timeout.
        exp_q.push_back(40'h11_22_33_44_55);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        err_seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            err_seen |= frame_err;
        end
        send_byte(8'h33, 0);
        err_seen |= frame_err;
        for (int i = 0; i < 7; i++) begin
            tick();
            err_seen |= frame_err;
        end
        send_byte(8'h44, 0);
        err_seen |= frame_err;
        send_byte(8'h55, 0);
        chk("race_no_err", {39'd0, err_seen}, 40'd0);
        chk("race_valid", {39'd0, rx_valid_out}, 40'd1);
        tick();
`else
        dec_ready_in = 1'b1;
        exp_q.push_back(40'h13_57_9B_DF_02);
        send_byte(8'h13, 0);
        send_byte(8'h57, 0);
        err_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            err_seen |= frame_err | rx_valid_out | ~in_ready;
        end
        chk("stall_no_drop", {39'd0, err_seen}, 40'd0);
        send_byte(8'h9B, 0);
        send_byte(8'hDF, 0);
        send_byte(8'h02, 0);
        chk("stall_valid", {39'd0, rx_valid_out}, 40'd1);
        tick();
`endif

        tick();
        chk("sb_drained", 40'(exp_q.size()), 40'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rx_stage.md
# rx_stage

Byte-serial instruction receiver sitting directly upstream of `decode_stage`. Accepts one byte per valid/ready handshake from the host pins and assembles a 5-byte frame (op, a1, a2, b1, b2). It then holds the frame on its outputs with `rx_valid_out` asserted until decode accepts it via `alu_ready_out` → `dec_ready_in`. An optional idle timer discards stalled partial frames.

## Interface
- `TIMEOUT_CYCLES`, default 255: consecutive idle cycles mid-frame before the partial frame is discarded. Only used with `RX_TIMEOUT_EN`. Legal range 1..65535.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  host byte strobe.
- `in_data`  in  8  host byte.
- `in_ready`  out  1  receiver can accept a byte this cycle.
- `dec_ready_in`  in  1  decode ready to take a frame (driven by `decode_stage.alu_ready_out`).
- `rx_valid_out`  out  1  complete frame present (drives `decode_stage.rx_valid_in`).
- `op`, `a1`, `a2`, `b1`, `b2`  out  8 each  assembled frame fields.
- `frame_err`  out  1  one-cycle pulse when a partial frame is dropped by timeout.

## Operation
- FSM in `alu_pkg::rx_state_t` with three states: IDLE (count 0), COLLECT (1..4 bytes held), HOLD (frame complete).
- Byte accept: `in_valid && in_ready` at a rising edge.
- `in_ready` = 1 in IDLE and COLLECT, 0 in HOLD. It is decoded from the state register.
- Byte order is fixed: byte 0→`op`, 1→`a1`, 2→`a2`, 3→`b1`, 4→`b2`.
- A 3-bit counter indexes the field register written. Each field is written only on its accept.
- Transitions:
  - IDLE→COLLECT on byte 0.
  - COLLECT stays while count < 4.
  - COLLECT→HOLD on accepting byte 4; counter → 0.
  - HOLD→IDLE at the edge where `rx_valid_out && dec_ready_in`.
- `rx_valid_out` = (state == HOLD), registered.
- Field outputs are stable for the whole time `rx_valid_out` is high. They keep their last values after transfer; only fresh accepts overwrite them.
- `in_valid` in HOLD: ignored, no byte lost from the frame. The host must hold the byte until `in_ready` returns.
- `dec_ready_in` outside HOLD: ignored.
- Reset mid-frame or mid-HOLD: the frame is discarded immediately (asynchronous), FSM → IDLE.

## Timing
- Reset values: `in_ready`=1, `rx_valid_out`=0, `op`/`a1`/`a2`/`b1`/`b2`=8'h00, `frame_err`=0, counter=0, idle timer=0.
- Fifth byte accepted at edge k → `rx_valid_out`=1 after edge k. Assembly adds zero extra cycles.
- Minimum frame period is 6 cycles: 5 accepts, plus ≥1 HOLD cycle, since `in_ready` is low throughout HOLD.
- Transfer at edge m (valid && ready) → `rx_valid_out`=0 and `in_ready`=1 after edge m. The next byte can be accepted at edge m+1.
- With `dec_ready_in` held high, HOLD lasts exactly 1 cycle.

## Configuration
- Macro `RX_TIMEOUT_EN`.
- Defined:
  - In COLLECT, a 16-bit idle counter increments each cycle with no accept. Any accept clears it.
  - On reaching `TIMEOUT_CYCLES`, at that edge: FSM → IDLE, byte counter → 0, idle counter → 0, `frame_err`=1 for exactly one cycle.
  - Field registers are not cleared.
  - If a byte is accepted in the same cycle the count would expire, the accept wins and no timeout occurs.
  - The timer is inactive in IDLE and HOLD.
- Undefined: no timer logic; `frame_err` is tied to 0; a partial frame waits indefinitely.

## Structure
- In `alu_pkg`:
  - `FRAME_BYTES` = 5
  - `rx_state_t` enum {RX_IDLE, RX_COLLECT, RX_HOLD}
  - `RX_TMO_W` = 16
- Sub-module `rx_idle_timer` (`clk`, `rst_n`, `run`, `clear`, `expired`), instantiated only under `RX_TIMEOUT_EN`.
- Bench: `rx_tb` wrapper exposing all pins, plus an integration bench chaining `rx_stage` → `decode_stage`.

## Test plan
- **Reset:** pulse `rst_n` low mid-stream → all outputs at the reset values above, `in_ready`=1.
- **Basic frame:** send 8'h01, 8'h11, 8'h22, 8'h33, 8'h44 back-to-back with `dec_ready_in`=1 → after the 5th edge `rx_valid_out`=1 and `op`=01, `a1`=11, `a2`=22, `b1`=33, `b2`=44; one cycle later `rx_valid_out`=0 and `in_ready`=1.
- **Backpressure:** `dec_ready_in`=0 for 10 cycles after frame complete, `in_valid`=1 with 8'hFF → `rx_valid_out` and the fields hold, `in_ready`=0, and 8'hFF is not captured. Raise `dec_ready_in` → transfer in 1 cycle, then the next frame accepts 8'hFF as `op`.
- **Gapped input:** bytes with 3 idle cycles between each → the same fields as the basic frame; `rx_valid_out` rises on the edge of the 5th accept.
- **Timeout (`RX_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8):** send 2 bytes, then idle → `frame_err` pulses 1 cycle after 8 idle edges. A following 5-byte frame 02,05,06,07,08 yields `op`=02.
- **Timeout race:** an accept on the expiring cycle → no `frame_err`, and the count continues.
